crc_frame_checker: RTL and testbench
====================================

// Module: crc_frame_checker
// PURPOSE
// Parametrised serial CRC checker for tracker / energy-detector front-end data streams in the event builder.
// - Computes the CRC of a bit-serial frame, MSB first, and compares it with the CRC_W-bit CRC appended by the front-end board.
// - Reports per-frame pass/fail, bit count and overflow.
// - Keeps a saturating error counter per instance; one instance per front-end link, tagged by Address.
// PARAMETERS
// CRC_W    6           CRC width; generator G(x) = x^CRC_W + POLY
// POLY     6'b100101   low CRC_W coefficients of G(x)
// CHECK_EN 1           1: received CRC follows data and is compared; 0: compute only, no RX phase
// LEN_W    12          width of frame bit counter
// MAX_BITS 4095        data bits allowed without Stop before the frame is aborted
// CNT_W    16          width of saturating error counter
// PORTS
// Clock    in   1      system clock
// Reset    in   1      synchronous, active-high
// Address  in   4      link tag, copied to DoneAddr at frame end
// Start    in   1      1-cycle pulse; Din on this cycle is data bit 0
// Stop     in   1      high on the cycle before the last data bit (i.e. with the penultimate bit)
// Din      in   1      serial data, one bit per cycle while Busy
// ClrCnt   in   1      synchronous clear of ErrCnt
// Busy     out  1      frame in progress (DATA, LAST or RXCRC)
// Done     out  1      1-cycle pulse at frame end
// DoneAddr out  4      Address captured at Start
// CRC      out  CRC_W  computed CRC of the last frame
// RxCrc    out  CRC_W  received CRC of the last frame (0 if CHECK_EN=0)
// CrcOk    out  1      CRC==RxCrc for the last frame (forced 1 if CHECK_EN=0; 0 on overflow)
// NBits    out  LEN_W  data bits in the last frame
// Overflow out  1      last frame aborted at MAX_BITS
// ErrCnt   out  CNT_W  frames with CrcOk=0; saturates at all-ones
// BEHAVIOUR
// CRC arithmetic
// - r = remainder of M(x)*x^CRC_W mod G(x); init 0.
// - Per data bit: fb = Din ^ r[CRC_W-1]; r <= {r[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
// - No flush cycles are needed.
// States: IDLE -> DATA -> LAST -> RXCRC -> DONE -> IDLE.
// - IDLE: Start=1 -> DATA; absorbs bit 0; bit count=1; latch Address. If Stop is also high -> LAST.
// - DATA: absorbs Din; bit count +1; Stop=1 -> LAST.
//   - Count reaching MAX_BITS with no Stop -> DONE with Overflow=1, CrcOk=0.
// - LAST: absorbs the final data bit -> RXCRC (CHECK_EN=1) or DONE (CHECK_EN=0).
// - RXCRC: shifts Din into the RX register MSB first for exactly CRC_W cycles, then -> DONE.
// - DONE: one cycle; Done=1; all result outputs updated in this cycle; ErrCnt +1 if !CrcOk; -> IDLE.
// Timing
// - Minimum frame is 2 data bits (Start and Stop on the same cycle).
// - Latency: Done asserts the cycle after the last RX CRC bit (CHECK_EN=0: after the last data bit).
// Outputs
// - Result outputs hold until the next DONE.
// - Reset clears every output and register to 0 (CrcOk=0, Overflow=0, ErrCnt=0) and returns to IDLE.
// Edge cases
// - Start while Busy or in DONE: ignored; no restart.
// - Stop in IDLE, RXCRC or LAST: ignored.
// - Reset mid-frame: frame discarded; no Done; ErrCnt cleared.
// - ClrCnt and error increment in the same cycle: ClrCnt wins (ErrCnt=0).
// - Reset has priority over ClrCnt.
// TESTING (defaults: CRC_W=6, POLY=6'b100101)
// T1: frame "10" (c0: Start=1,Stop=1,Din=1; c1: Din=0), then RX 101111 on c2-c7
//     -> Done on c8; CRC=101111; CrcOk=1; NBits=2; ErrCnt=0.
// T2: frame "01", then RX 100100 -> CRC=100101; CrcOk=0; ErrCnt=1. Repeat until ErrCnt=FFFF; one more -> stays FFFF.
// T3: Start, then no Stop for 4095 bits -> Done with Overflow=1, CrcOk=0, NBits=4095; ErrCnt +1.
// T4: pulse Start during DATA/RXCRC of a "10" frame -> ignored; results identical to T1.
// T5: Reset asserted on c4 of T1 -> no Done, all outputs 0; a new "10" frame passes.
// T6: CHECK_EN=0, frame "10" -> Done on c2; CRC=101111; RxCrc=0; CrcOk=1.
//     ClrCnt coincident with a failing Done -> ErrCnt=0.

Source files
------------

// File: rtl/crc_frame_checker.sv
// Bit-serial CRC checker for one front-end link: computes the CRC of an MSB-first frame,
// compares it with the trailing received CRC and keeps a saturating error count.
module crc_frame_checker #(
  parameter int unsigned          CRC_W    = 6,
  parameter logic [CRC_W-1:0]     POLY     = 6'b100101,
  parameter bit                   CHECK_EN = 1'b1,
  parameter int unsigned          LEN_W    = 12,
  parameter int unsigned          MAX_BITS = 4095,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [3:0]       Address,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Din,
  input  logic             ClrCnt,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       DoneAddr,
  output logic [CRC_W-1:0] CRC,
  output logic [CRC_W-1:0] RxCrc,
  output logic             CrcOk,
  output logic [LEN_W-1:0] NBits,
  output logic             Overflow,
  output logic [CNT_W-1:0] ErrCnt
);

  localparam int unsigned      RxCntW  = $clog2(CRC_W) + 1;
  localparam logic [RxCntW-1:0] RxLast = RxCntW'(CRC_W - 1);
  localparam logic [LEN_W-1:0] MaxBits = LEN_W'(MAX_BITS);

  typedef enum logic [2:0] {StIdle, StData, StLast, StRxCrc, StDone} state_e;

  state_e              state_q, state_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [CRC_W-1:0]    rx_q, rx_d;
  logic [LEN_W-1:0]    nbits_q, nbits_d;
  logic [RxCntW-1:0]   rxcnt_q, rxcnt_d;
  logic [3:0]          addr_q, addr_d;

  logic [CRC_W-1:0]    res_crc_q, res_crc_d;
  logic [CRC_W-1:0]    res_rx_q, res_rx_d;
  logic                res_ok_q, res_ok_d;
  logic [LEN_W-1:0]    res_nbits_q, res_nbits_d;
  logic                res_ovf_q, res_ovf_d;
  logic [3:0]          res_addr_q, res_addr_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic                fb;
  logic [CRC_W-1:0]    crc_step;
  logic [LEN_W-1:0]    nbits_inc;
  logic                abort;
  logic                enter_done;

  // One LFSR step of the remainder register for the current data bit.
  always_comb begin
    fb       = Din ^ crc_q[CRC_W-1];
    crc_step = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    nbits_inc = nbits_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    nbits_d = nbits_q;
    rxcnt_d = rxcnt_q;
    addr_d  = addr_q;
    abort   = 1'b0;

    case (state_q)
      StIdle: begin
        if (Start) begin
          // Remainder starts at zero, so the first step reduces to a conditional POLY.
          crc_d   = Din ? POLY : '0;
          nbits_d = LEN_W'(1);
          addr_d  = Address;
          rx_d    = '0;
          rxcnt_d = '0;
          state_d = Stop ? StLast : StData;
        end
      end
      StData: begin
        crc_d   = crc_step;
        nbits_d = nbits_inc;
        if (Stop) begin
          state_d = StLast;
        end else if (nbits_inc == MaxBits) begin
          state_d = StDone;
          abort   = 1'b1;
        end
      end
      StLast: begin
        crc_d   = crc_step;
        nbits_d = nbits_inc;
        state_d = CHECK_EN ? StRxCrc : StDone;
      end
      StRxCrc: begin
        rx_d    = {rx_q[CRC_W-2:0], Din};
        rxcnt_d = rxcnt_q + 1'b1;
        if (rxcnt_q == RxLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Results are captured on the edge into StDone so they are already valid while Done is high.
  always_comb begin
    enter_done  = (state_d == StDone) && (state_q != StDone);
    res_crc_d   = res_crc_q;
    res_rx_d    = res_rx_q;
    res_ok_d    = res_ok_q;
    res_nbits_d = res_nbits_q;
    res_ovf_d   = res_ovf_q;
    res_addr_d  = res_addr_q;
    if (enter_done) begin
      res_crc_d   = crc_d;
      res_rx_d    = (CHECK_EN && !abort) ? rx_d : '0;
      res_nbits_d = nbits_d;
      res_ovf_d   = abort;
      res_addr_d  = addr_q;
      if (abort) begin
        res_ok_d = 1'b0;
      end else if (CHECK_EN) begin
        res_ok_d = (crc_d == rx_d);
      end else begin
        res_ok_d = 1'b1;
      end
    end
  end

  // ClrCnt overrides a coincident increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ClrCnt) begin
      err_cnt_d = '0;
    end else if ((state_q == StDone) && !res_ok_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      crc_q       <= '0;
      rx_q        <= '0;
      nbits_q     <= '0;
      rxcnt_q     <= '0;
      addr_q      <= '0;
      res_crc_q   <= '0;
      res_rx_q    <= '0;
      res_ok_q    <= 1'b0;
      res_nbits_q <= '0;
      res_ovf_q   <= 1'b0;
      res_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      rx_q        <= rx_d;
      nbits_q     <= nbits_d;
      rxcnt_q     <= rxcnt_d;
      addr_q      <= addr_d;
      res_crc_q   <= res_crc_d;
      res_rx_q    <= res_rx_d;
      res_ok_q    <= res_ok_d;
      res_nbits_q <= res_nbits_d;
      res_ovf_q   <= res_ovf_d;
      res_addr_q  <= res_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    Busy     = (state_q == StData) || (state_q == StLast) || (state_q == StRxCrc);
    Done     = (state_q == StDone);
    DoneAddr = res_addr_q;
    CRC      = res_crc_q;
    RxCrc    = res_rx_q;
    CrcOk    = res_ok_q;
    NBits    = res_nbits_q;
    Overflow = res_ovf_q;
    ErrCnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Randomized scoreboard bench: one checker with the RX phase and one compute-only checker,
// both compared against a polynomial long-division reference.
module tb_crc_frame_checker;

  localparam int CW = 6;
  localparam logic [5:0] PL = 6'b100101;
  localparam int LW = 12;
  localparam int MB = 4095;
  localparam int NW = 4;
  localparam logic [NW-1:0] SAT = '1;

  logic Clock = 1'b0;
  logic Reset;

  logic [3:0] a_address, b_address;
  logic a_start, a_stop, a_din, a_clr, b_start, b_stop, b_din, b_clr;
  logic a_busy, a_done, a_ok, a_ovf, b_busy, b_done, b_ok, b_ovf;
  logic [3:0] a_daddr, b_daddr;
  logic [CW-1:0] a_crc, a_rx, b_crc, b_rx;
  logic [LW-1:0] a_nbits, b_nbits;
  logic [NW-1:0] a_err, b_err;

  crc_frame_checker #(.CRC_W(CW), .POLY(PL), .CHECK_EN(1'b1), .LEN_W(LW), .MAX_BITS(MB),
                      .CNT_W(NW)) dut_a (
    .Clock(Clock), .Reset(Reset), .Address(a_address), .Start(a_start), .Stop(a_stop),
    .Din(a_din), .ClrCnt(a_clr), .Busy(a_busy), .Done(a_done), .DoneAddr(a_daddr),
    .CRC(a_crc), .RxCrc(a_rx), .CrcOk(a_ok), .NBits(a_nbits), .Overflow(a_ovf), .ErrCnt(a_err)
  );

  crc_frame_checker #(.CRC_W(CW), .POLY(PL), .CHECK_EN(1'b0), .LEN_W(LW), .MAX_BITS(MB),
                      .CNT_W(NW)) dut_b (
    .Clock(Clock), .Reset(Reset), .Address(b_address), .Start(b_start), .Stop(b_stop),
    .Din(b_din), .ClrCnt(b_clr), .Busy(b_busy), .Done(b_done), .DoneAddr(b_daddr),
    .CRC(b_crc), .RxCrc(b_rx), .CrcOk(b_ok), .NBits(b_nbits), .Overflow(b_ovf), .ErrCnt(b_err)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [5:0]    crc;
    logic [5:0]    rx;
    logic          ok;
    int            nbits;
    logic          ovf;
    logic [3:0]    addr;
    logic          chk_crc;
    logic [NW-1:0] err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  bit   fbits[$];
  int   checks = 0;
  int   errors = 0;
  int   err_a = 0;
  int   err_b = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Remainder of M(x)*x^CW divided by G(x), by textbook long division.
  function automatic logic [5:0] ref_crc();
    bit m[$];
    logic [6:0] g;
    logic [5:0] r;
    g = {1'b1, PL};
    m = fbits;
    repeat (CW) m.push_back(1'b0);
    for (int i = 0; i < fbits.size(); i++)
      if (m[i])
        for (int j = 0; j <= CW; j++) m[i+j] = m[i+j] ^ g[CW-j];
    for (int j = 0; j < CW; j++) r[CW-1-j] = m[fbits.size()+j];
    return r;
  endfunction

  task automatic cmp(input bit which, input exp_t e);
    string p;
    p = which ? "b_" : "a_";
    if (e.chk_crc) check({p, "crc"}, which ? b_crc : a_crc, e.crc);
    check({p, "rxcrc"},    which ? b_rx : a_rx, e.rx);
    check({p, "crcok"},    which ? b_ok : a_ok, e.ok);
    check({p, "nbits"},    which ? b_nbits : a_nbits, e.nbits);
    check({p, "overflow"}, which ? b_ovf : a_ovf, e.ovf);
    check({p, "doneaddr"}, which ? b_daddr : a_daddr, e.addr);
  endtask

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge Clock);
      if (a_done) begin
        if (qa.size() == 0) begin
          check("a_spurious_done", a_done, 1'b0);
        end else begin
          e = qa.pop_front();
          cmp(1'b0, e);
          @(negedge Clock);
          check("a_errcnt", a_err, e.err);
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge Clock);
      if (b_done) begin
        if (qb.size() == 0) begin
          check("b_spurious_done", b_done, 1'b0);
        end else begin
          e = qb.pop_front();
          cmp(1'b1, e);
          @(negedge Clock);
          check("b_errcnt", b_err, e.err);
        end
      end
    end
  end

  task automatic drv(input bit which, input logic st, input logic sp, input logic d,
                     input logic [3:0] ad, input logic clr);
    if (!which) begin
      a_start = st; a_stop = sp; a_din = d; a_address = ad; a_clr = clr;
    end else begin
      b_start = st; b_stop = sp; b_din = d; b_address = ad; b_clr = clr;
    end
    @(posedge Clock);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  // Sends the frame held in fbits; which=0 targets the RX-checking instance.
  task automatic send_frame(input bit which, input logic [5:0] rx, input logic [3:0] addr,
                            input bit glitch, input bit clr, input bit ovf);
    exp_t e;
    int n;
    int cur;
    n = fbits.size();
    e.crc     = ref_crc();
    e.rx      = (which || ovf) ? 6'd0 : rx;
    e.ok      = ovf ? 1'b0 : (which ? 1'b1 : (e.crc == rx));
    e.nbits   = n;
    e.ovf     = ovf;
    e.addr    = addr;
    e.chk_crc = !ovf;
    cur = which ? err_b : err_a;
    if (!e.ok && cur != int'(SAT)) cur++;
    if (clr) cur = 0;
    e.err = NW'(cur);
    if (which) begin err_b = cur; qb.push_back(e); end
    else begin err_a = cur; qa.push_back(e); end

    for (int k = 0; k < n; k++) begin
      drv(which, (k == 0) ? 1'b1 : (glitch && ($urandom_range(0, 3) == 0)),
          !ovf && (k == n - 2), fbits[k], (k == 0) ? addr : 4'($urandom), 1'b0);
      if (k == 0) check("busy_in_frame", which ? b_busy : a_busy, 1'b1);
    end
    if (!which && !ovf)
      for (int i = 0; i < CW; i++)
        drv(which, glitch && rnd_bit(), rnd_bit(), rx[CW-1-i], 4'($urandom), 1'b0);
    check(which ? "b_done_latency" : "a_done_latency", which ? b_done : a_done, 1'b1);
    drv(which, glitch && rnd_bit(), 1'b0, rnd_bit(), 4'($urandom), clr);
    drv(which, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat ($urandom_range(0, 2)) drv(which, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic set_bits(input logic [1:0] v);
    fbits.delete();
    fbits.push_back(v[1]);
    fbits.push_back(v[0]);
  endtask

  task automatic rand_bits(input int n);
    fbits.delete();
    repeat (n) fbits.push_back(rnd_bit());
  endtask

  initial begin : stim
    logic [5:0] rx;
    Reset = 1'b1;
    a_start = 0; a_stop = 0; a_din = 0; a_address = 0; a_clr = 0;
    b_start = 0; b_stop = 0; b_din = 0; b_address = 0; b_clr = 0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    check("reset_a_lo", {a_busy, a_done, a_daddr, a_crc, a_rx, a_ok}, 0);
    check("reset_a_hi", {a_nbits, a_ovf, a_err}, 0);
    check("reset_b", {b_busy, b_done, b_crc, b_rx, b_ok, b_nbits, b_ovf, b_err}, 0);

    // Frame "10" with the matching CRC, then known constants.
    set_bits(2'b10);
    send_frame(1'b0, 6'b101111, 4'hA, 1'b0, 1'b0, 1'b0);
    check("t1_crc_const", a_crc, 6'b101111);
    check("t1_ok_const", a_ok, 1'b1);

    // Failing "01" frame with ClrCnt in its Done cycle, then saturate the counter.
    set_bits(2'b01);
    send_frame(1'b0, 6'b100100, 4'h3, 1'b0, 1'b1, 1'b0);
    check("t2_crc_const", a_crc, 6'b100101);
    for (int i = 0; i < int'(SAT) + 2; i++)
      send_frame(1'b0, 6'b100100, 4'(i), 1'b0, 1'b0, 1'b0);
    check("t2_saturated", a_err, SAT);

    // Start pulses during DATA/RXCRC/DONE must be ignored.
    set_bits(2'b10);
    send_frame(1'b0, 6'b101111, 4'h5, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rand_bits($urandom_range(2, 40));
      rx = rnd_bit() ? ref_crc() : 6'($urandom);
      send_frame(1'b0, rx, 4'($urandom), rnd_bit(), ($urandom_range(0, 5) == 0), 1'b0);
    end

    // Overflow: no Stop for MAX_BITS bits.
    rand_bits(MB);
    send_frame(1'b0, 6'd0, 4'hC, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of the RX phase of a "10" frame.
    drv(1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    Reset = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    Reset = 1'b0;
    err_a = 0;
    err_b = 0;
    check("t5_reset_a_lo", {a_busy, a_done, a_daddr, a_crc, a_rx, a_ok}, 0);
    check("t5_reset_a_hi", {a_nbits, a_ovf, a_err}, 0);
    repeat (10) drv(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    set_bits(2'b10);
    send_frame(1'b0, 6'b101111, 4'h9, 1'b0, 1'b0, 1'b0);

    // Compute-only instance.
    set_bits(2'b10);
    send_frame(1'b1, 6'd0, 4'h6, 1'b0, 1'b0, 1'b0);
    check("t6_crc_const", b_crc, 6'b101111);
    for (int i = 0; i < 8; i++) begin
      rand_bits($urandom_range(2, 30));
      send_frame(1'b1, 6'd0, 4'($urandom), rnd_bit(), 1'b0, 1'b0);
    end

    for (int i = 0; i < 20 && (qa.size() + qb.size()) != 0; i++) @(posedge Clock);
    repeat (3) @(posedge Clock);
    check("queues_drained", qa.size() + qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
